// File: rtl/adc_pkg.sv
// Shared constants, FSM state type and channel-sequencing helpers for the ADC scan scheduler.
package adc_pkg;

   localparam int unsigned NUM_CHAN = 8;
   localparam int unsigned RES_W    = 12;
   localparam int unsigned CH_W     = 3;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StStore,
      StGap
   } state_e;

   // Next set bit of mask strictly after cur, wrapping; returns cur if it is the only one.
   function automatic logic [CH_W-1:0] next_chan(input logic [NUM_CHAN-1:0] mask,
                                                 input logic [CH_W-1:0]     cur);
      logic [CH_W-1:0] res;
      logic [CH_W-1:0] cand;
      logic            found;
      res   = cur;
      found = 1'b0;
      for (int unsigned i = 1; i <= NUM_CHAN; i++) begin
         cand = cur + CH_W'(i);
         if (!found && mask[cand]) begin
            res   = cand;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   // Frames in a scan round: one per masked channel plus the priming frame.
   function automatic logic [3:0] frames_for(input logic [NUM_CHAN-1:0] mask);
      logic [3:0] n;
      n = 4'd1;
      for (int unsigned i = 0; i < NUM_CHAN; i++) begin
         n = n + {3'd0, mask[CH_W'(i)]};
      end
      return n;
   endfunction

endpackage

// File: rtl/adc_result_regfile.sv
// Per-channel result store: one write port, one registered read port, sticky valid bits.
module adc_result_regfile
   import adc_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_addr,
   input  logic [RES_W-1:0]    wr_data,
   input  logic [CH_W-1:0]     rd_addr,
   output logic [RES_W-1:0]    rd_data,
   output logic [NUM_CHAN-1:0] valid
);

   logic [RES_W-1:0]    mem_q [NUM_CHAN];
   logic [RES_W-1:0]    rd_data_q;
   logic [NUM_CHAN-1:0] valid_q;

   // Read samples the pre-write contents, so a same-cycle write shows up one read later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q     <= '{default: '0};
         valid_q   <= '0;
         rd_data_q <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wr_addr]   <= wr_data;
            valid_q[wr_addr] <= 1'b1;
         end
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;
   assign valid   = valid_q;

endmodule

// File: rtl/adc_scan_ctrl.sv
// Scan scheduler for the adc_18s022 driver: round-robin channel scans, one-shot requests and a
// per-channel result file, accounting for the driver returning the previous frame's channel.
module adc_scan_ctrl
   import adc_pkg::*;
#(
   parameter logic [15:0] INTERVAL_CYC = 16'd50000,
   parameter logic [11:0] TIMEOUT_CYC  = 12'd1023
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic                Scan_en,
   input  logic [NUM_CHAN-1:0] Chan_mask,
   input  logic                Single_req,
   input  logic [CH_W-1:0]     Single_chan,
   input  logic                Err_clr,
   output logic                En_convert,
   output logic [CH_W-1:0]     Adc_channel,
   input  logic                Convert_done,
   input  logic                Adc_state,
   input  logic [RES_W-1:0]    Adc_result,
   input  logic [CH_W-1:0]     Rd_addr,
   output logic [RES_W-1:0]    Rd_data,
   output logic [NUM_CHAN-1:0] Data_valid,
   output logic                Scan_done,
   output logic                Single_done,
   output logic                Timeout_err
);

   state_e              state_q, state_d;
   logic [15:0]         timer_q;
   logic [NUM_CHAN-1:0] job_mask_q;
   logic                job_single_q;
   logic [3:0]          frames_left_q;
   logic [CH_W-1:0]     chan_q, prev_chan_q, pend_chan_q;
   logic                prev_valid_q, pend_q, err_q, scan_done_q, single_done_q;
   logic [RES_W-1:0]    result_q;

   logic gap_expired, wait_timeout, last_frame;
   logic en_convert, store_wr, job_start, job_done, timeout_hit, gap_restart;

   assign gap_expired  = timer_q >= (INTERVAL_CYC - 16'd1);
   assign wait_timeout = timer_q == {4'd0, TIMEOUT_CYC};
   assign last_frame   = frames_left_q == 4'd0;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Pending one-shots win at every job boundary; a zero mask keeps the gap looping.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (pend_q) begin
               state_d = StIssue;
            end else if (Scan_en) begin
               state_d = (Chan_mask != '0) ? StIssue : StGap;
            end
         end
         StIssue: begin
            if (!Adc_state) state_d = StWait;
         end
         StWait: begin
            if (Convert_done) begin
               state_d = StStore;
            end else if (wait_timeout) begin
               state_d = StGap;
            end
         end
         StStore: begin
            if (!last_frame) begin
               state_d = StIssue;
            end else begin
               state_d = Scan_en ? StGap : StIdle;
            end
         end
         StGap: begin
            if (pend_q) begin
               state_d = StIssue;
            end else if (gap_expired) begin
               if (!Scan_en) begin
                  state_d = StIdle;
               end else if (Chan_mask != '0) begin
                  state_d = StIssue;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      en_convert  = (state_q == StIssue) && !Adc_state;
      store_wr    = (state_q == StStore) && prev_valid_q;
      job_start   = ((state_q == StIdle) || (state_q == StGap)) && (state_d == StIssue);
      job_done    = (state_q == StStore) && last_frame;
      timeout_hit = (state_q == StWait) && !Convert_done && wait_timeout;
      gap_restart = (state_d == StGap) && ((state_q != StGap) || gap_expired);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         timer_q       <= '0;
         job_mask_q    <= '0;
         job_single_q  <= 1'b0;
         frames_left_q <= '0;
         chan_q        <= '0;
         prev_chan_q   <= '0;
         prev_valid_q  <= 1'b0;
         result_q      <= '0;
      end else begin
         if (en_convert || gap_restart) begin
            timer_q <= '0;
         end else if ((state_q == StWait) || (state_q == StGap)) begin
            timer_q <= timer_q + 16'd1;
         end

         // A one-shot is a two-frame job on a one-hot mask, so it reuses the scan sequencing.
         if (job_start) begin
            prev_valid_q <= 1'b0;
            if (pend_q) begin
               job_single_q  <= 1'b1;
               job_mask_q    <= NUM_CHAN'(1) << pend_chan_q;
               frames_left_q <= 4'd2;
               chan_q        <= pend_chan_q;
            end else begin
               job_single_q  <= 1'b0;
               job_mask_q    <= Chan_mask;
               frames_left_q <= frames_for(Chan_mask);
               chan_q        <= next_chan(Chan_mask, CH_W'(NUM_CHAN - 1));
            end
         end else if (en_convert) begin
            frames_left_q <= frames_left_q - 4'd1;
         end else if (state_q == StStore) begin
            prev_chan_q  <= chan_q;
            prev_valid_q <= !last_frame;
            if (!last_frame) chan_q <= next_chan(job_mask_q, chan_q);
         end else if (timeout_hit) begin
            prev_valid_q <= 1'b0;
         end

         if ((state_q == StWait) && Convert_done) result_q <= Adc_result;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         pend_q        <= 1'b0;
         pend_chan_q   <= '0;
         err_q         <= 1'b0;
         scan_done_q   <= 1'b0;
         single_done_q <= 1'b0;
      end else begin
         // A request arriving while its predecessor starts stays queued behind it.
         if (Single_req) begin
            pend_q      <= 1'b1;
            pend_chan_q <= Single_chan;
         end else if (job_start && pend_q) begin
            pend_q <= 1'b0;
         end

         if (timeout_hit) begin
            err_q <= 1'b1;
         end else if (Err_clr) begin
            err_q <= 1'b0;
         end

         scan_done_q   <= job_done && !job_single_q;
         single_done_q <= job_done && job_single_q;
      end
   end

   adc_result_regfile u_regfile (
      .clk     (Clk),
      .rst_n   (Rst_n),
      .wr_en   (store_wr),
      .wr_addr (prev_chan_q),
      .wr_data (result_q),
      .rd_addr (Rd_addr),
      .rd_data (Rd_data),
      .valid   (Data_valid)
   );

   assign En_convert  = en_convert;
   assign Adc_channel = chan_q;
   assign Scan_done   = scan_done_q;
   assign Single_done = single_done_q;
   assign Timeout_err = err_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench for adc_scan_ctrl with a behavioural driver that returns the previous frame's
// channel as 12'h100+ch; expected frames and completions are queued by a job-level model.
module tb_adc_scan_ctrl;
   localparam logic [15:0] INTERVAL = 16'd40;
   localparam logic [11:0] TMO      = 12'd1023;

   logic        Clk = 1'b0;
   logic        Rst_n, Scan_en, Single_req, Err_clr;
   logic [7:0]  Chan_mask;
   logic [2:0]  Single_chan, Rd_addr, Adc_channel;
   logic        En_convert, Convert_done, Adc_state;
   logic        Scan_done, Single_done, Timeout_err;
   logic [11:0] Adc_result, Rd_data;
   logic [7:0]  Data_valid;

   adc_scan_ctrl #(
      .INTERVAL_CYC (INTERVAL),
      .TIMEOUT_CYC  (TMO)
   ) dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .Scan_en      (Scan_en),
      .Chan_mask    (Chan_mask),
      .Single_req   (Single_req),
      .Single_chan  (Single_chan),
      .Err_clr      (Err_clr),
      .En_convert   (En_convert),
      .Adc_channel  (Adc_channel),
      .Convert_done (Convert_done),
      .Adc_state    (Adc_state),
      .Adc_result   (Adc_result),
      .Rd_addr      (Rd_addr),
      .Rd_data      (Rd_data),
      .Data_valid   (Data_valid),
      .Scan_done    (Scan_done),
      .Single_done  (Single_done),
      .Timeout_err  (Timeout_err)
   );

   always #5 Clk = ~Clk;

   int unsigned n_chk = 0, n_fail = 0;
   int unsigned cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic void fail_now(string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s", name);
   endfunction

   // Behavioural driver: busy for a random latency, then returns the previous frame's channel.
   logic        withhold = 1'b0;
   logic        busy, last_ok;
   int unsigned lat;
   logic [2:0]  cur_ch, last_ch;
   assign Adc_state = busy;

   always @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         busy <= 1'b0; Convert_done <= 1'b0; Adc_result <= '0; lat <= 0;
         last_ok <= 1'b0; cur_ch <= '0; last_ch <= '0;
      end else begin
         Convert_done <= 1'b0;
         if (busy) begin
            if (lat == 0) begin
               busy         <= 1'b0;
               Convert_done <= 1'b1;
               Adc_result   <= last_ok ? 12'h100 + {9'd0, last_ch} : 12'hEEE;
               last_ch      <= cur_ch;
               last_ok      <= 1'b1;
            end else begin
               lat <= lat - 1;
            end
         end else if (En_convert && !withhold) begin
            busy   <= 1'b1;
            cur_ch <= Adc_channel;
            lat    <= $urandom_range(6, 1);
         end
      end
   end

   // Scoreboard queues and reference result file.
   int unsigned exp_ch_q[$];
   logic [1:0]  exp_ev_q[$];   // {scan, single}
   logic [11:0] ref_file [8];
   logic [7:0]  ref_valid;
   int unsigned frames_seen = 0, ev_seen = 0, last_en_cyc = 0;

   always @(negedge Clk) begin
      if (Rst_n) begin
         if (En_convert) begin
            frames_seen++;
            last_en_cyc = cyc;
            if (exp_ch_q.size() == 0) fail_now("unexpected_frame");
            else chk("frame_chan", {29'd0, Adc_channel}, exp_ch_q.pop_front());
         end
         if (Scan_done || Single_done) begin
            ev_seen++;
            if (exp_ev_q.size() == 0) fail_now("unexpected_done");
            else chk("done_kind", {30'd0, Scan_done, Single_done}, {30'd0, exp_ev_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic push_round(input logic [7:0] mask);
      int lo = -1;
      for (int c = 0; c < 8; c++) begin
         if (mask[c]) begin
            if (lo < 0) lo = c;
            exp_ch_q.push_back(c);
            ref_file[c] = 12'h100 + 12'(c);
            ref_valid[c] = 1'b1;
         end
      end
      exp_ch_q.push_back(lo);   // closing frame fetches the last channel's data
      exp_ev_q.push_back(2'b10);
   endtask

   task automatic push_single(input logic [2:0] ch);
      exp_ch_q.push_back(ch);
      exp_ch_q.push_back(ch);
      exp_ev_q.push_back(2'b01);
      ref_file[ch] = 12'h100 + {9'd0, ch};
      ref_valid[ch] = 1'b1;
   endtask

   task automatic wait_ev(input int unsigned target, input string name);
      int unsigned n = 0;
      while (ev_seen < target && n < 1500) begin tick(); n++; end
      if (ev_seen < target) fail_now(name);
   endtask

   task automatic wait_frames(input int unsigned target, input string name);
      int unsigned n = 0;
      while (frames_seen < target && n < 1500) begin tick(); n++; end
      if (frames_seen < target) fail_now(name);
   endtask

   task automatic check_file();
      for (int c = 0; c < 8; c++) begin
         Rd_addr = 3'(c);
         tick();
         chk($sformatf("file[%0d]", c), {20'd0, Rd_data}, {20'd0, ref_file[c]});
      end
      chk("data_valid", {24'd0, Data_valid}, {24'd0, ref_valid});
   endtask

   task automatic ref_reset();
      exp_ch_q.delete();
      exp_ev_q.delete();
      for (int c = 0; c < 8; c++) ref_file[c] = '0;
      ref_valid = '0;
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      tick(); tick();
      ref_reset();
      Rst_n = 1'b1;
      tick();
   endtask

   task automatic run_round(input logic [7:0] mask);
      int unsigned t = ev_seen + 1;
      Chan_mask = mask;
      push_round(mask);
      Scan_en = 1'b1;
      tick();
      Scan_en = 1'b0;
      Chan_mask = 8'($urandom);
      wait_ev(t, "round_done_wait");
   endtask

   task automatic run_single(input logic [2:0] ch);
      int unsigned t = ev_seen + 1;
      push_single(ch);
      Single_chan = ch;
      Single_req = 1'b1;
      tick();
      Single_req = 1'b0;
      Single_chan = 3'($urandom);
      wait_ev(t, "single_done_wait");
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base, c0, n;
      logic [2:0] ch;
      Rst_n = 1'b0; Scan_en = 1'b0; Single_req = 1'b0; Err_clr = 1'b0;
      Chan_mask = '0; Single_chan = '0; Rd_addr = '0;
      ref_reset();
      tick(); tick();
      Rst_n = 1'b1;
      @(negedge Clk);
      chk("rst_en_convert", {31'd0, En_convert}, 0);
      chk("rst_adc_channel", {29'd0, Adc_channel}, 0);
      chk("rst_scan_done", {31'd0, Scan_done}, 0);
      chk("rst_single_done", {31'd0, Single_done}, 0);
      chk("rst_timeout_err", {31'd0, Timeout_err}, 0);
      chk("rst_rd_data", {20'd0, Rd_data}, 0);
      check_file();

      // Directed: mask 05 gives frames 0,2,0.
      run_round(8'h05);
      check_file();
      // Directed: one-shot on channel 7.
      run_single(3'd7);
      check_file();

      for (int it = 0; it < 6; it++) begin
         if ($urandom_range(1, 0) == 1) run_round(8'($urandom_range(255, 1)));
         else run_single(3'($urandom));
         check_file();
      end

      // One-shot requested mid-round with scanning held on: served at the start of the gap.
      ch = 3'($urandom);
      base = frames_seen;
      Chan_mask = 8'hFF;
      push_round(8'hFF);
      push_single(ch);
      c0 = ev_seen;
      Scan_en = 1'b1;
      wait_frames(base + 3, "midround_frames_wait");
      Single_chan = ch; Single_req = 1'b1; tick(); Single_req = 1'b0;
      wait_ev(c0 + 1, "midround_scan_wait");
      n = cyc;
      wait_frames(base + 10, "midround_single_wait");
      chk("oneshot_before_gap_end", {31'd0, (cyc - n) < INTERVAL}, 1);
      wait_ev(c0 + 2, "midround_single_done_wait");
      Scan_en = 1'b0;
      repeat (INTERVAL + 10) tick();
      check_file();

      // Driver withholds Convert_done: timeout, gap, then a freshly primed round.
      withhold = 1'b1;
      exp_ch_q.push_back(0);
      push_round(8'h03);
      c0 = ev_seen;
      Chan_mask = 8'h03;
      Scan_en = 1'b1;
      n = 0;
      while (!Timeout_err && n < 1300) begin @(negedge Clk); n++; end
      // TIMEOUT+1 full wait cycles, flag registered at the end of the last one.
      if (!Timeout_err) fail_now("timeout_flag_wait");
      else chk("timeout_latency", cyc - last_en_cyc, 32'(TMO) + 2);
      tick();
      withhold = 1'b0;
      wait_ev(c0 + 1, "post_timeout_round_wait");
      Scan_en = 1'b0;
      repeat (INTERVAL + 10) tick();
      chk("timeout_sticky", {31'd0, Timeout_err}, 1);
      Err_clr = 1'b1; tick(); Err_clr = 1'b0; tick();
      chk("timeout_cleared", {31'd0, Timeout_err}, 0);
      check_file();

      // Mask changed mid-round only takes effect on the next round.
      do_reset();
      base = frames_seen; c0 = ev_seen;
      push_round(8'h01);
      push_round(8'h80);
      Chan_mask = 8'h01;
      Scan_en = 1'b1;
      wait_frames(base + 1, "maskchg_first_frame");
      Chan_mask = 8'h80;
      wait_ev(c0 + 1, "maskchg_round1_wait");
      chk("maskchg_valid_r1", {24'd0, Data_valid}, 32'h01);
      wait_ev(c0 + 2, "maskchg_round2_wait");
      chk("maskchg_valid_r2", {24'd0, Data_valid}, 32'h81);
      Scan_en = 1'b0;
      repeat (INTERVAL + 10) tick();
      check_file();

      // Reset during WAIT clears everything; scanning then restarts with a priming frame.
      withhold = 1'b1;
      base = frames_seen;
      exp_ch_q.push_back(4);
      Chan_mask = 8'h10;
      Scan_en = 1'b1;
      wait_frames(base + 1, "rstwait_frame");
      tick(); tick();
      Rst_n = 1'b0;
      @(negedge Clk);
      chk("rstwait_en_convert", {31'd0, En_convert}, 0);
      chk("rstwait_adc_channel", {29'd0, Adc_channel}, 0);
      chk("rstwait_data_valid", {24'd0, Data_valid}, 0);
      chk("rstwait_done", {30'd0, Scan_done, Single_done}, 0);
      chk("rstwait_timeout", {31'd0, Timeout_err}, 0);
      chk("rstwait_rd_data", {20'd0, Rd_data}, 0);
      ref_reset();
      withhold = 1'b0;
      tick();
      c0 = ev_seen;
      push_round(8'h10);
      Rst_n = 1'b1;
      wait_ev(c0 + 1, "rstwait_round_wait");
      Scan_en = 1'b0;
      repeat (INTERVAL + 10) tick();
      check_file();

      chk("frames_outstanding", exp_ch_q.size(), 0);
      chk("events_outstanding", exp_ev_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
